// File: rtl/sha3_miner_csr_pkg.sv
// Shared constants for the SHA3 miner CSR block: word offsets of the
// Avalon register map and irq_ctrl bit positions.
package sha3_miner_pkg;

  localparam int NUM_WORDS = 8;

  localparam int HDR_BASE  = 'h00;
  localparam int DIFF_BASE = 'h08;
  localparam int NONCE_LO  = 'h10;
  localparam int NONCE_HI  = 'h11;
  localparam int CTRL      = 'h12;
  localparam int SOL_LO    = 'h13;
  localparam int SOL_HI    = 'h14;
  localparam int STATUS    = 'h15;
  localparam int IRQ_CTRL  = 'h16;
  localparam int CNT_LO    = 'h17;
  localparam int CNT_HI    = 'h18;

  localparam int IRQ_EN_BIT  = 0;
  localparam int IRQ_CLR_BIT = 1;

endpackage

// File: rtl/sha3_miner_csr_if.sv
// Avalon-MM slave bus seen by the CSR block (fixed read latency 1, no waitrequest).
interface sha3_miner_csr_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [31:0]       writedata;
  logic              read;
  logic [31:0]       readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/sha3_miner_csr_snap64_reader.sv
// Presents a 64-bit source as two 32-bit words; reading the lo word freezes
// the hi word so the pair is a coherent sample.
module snap64_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] src,
  input  logic        lo_rd,
  output logic [31:0] lo,
  output logic [31:0] hi_snap
);

  logic [31:0] hi_snap_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_snap_reg <= '0;
    end else if (lo_rd) begin
      hi_snap_reg <= src[63:32];
    end
  end

  assign lo      = src[31:0];
  assign hi_snap = hi_snap_reg;

endmodule

// File: rtl/sha3_miner_csr.sv
// Avalon-MM register bank in front of the SHA3-256 mining engine: engine
// inputs, captured results, sticky interrupt and elapsed-run counter.
module sha3_miner_csr
  import sha3_miner_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 18,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  sha3_miner_csr_if.slave   avs,
  output logic [255:0]      header,
  output logic [255:0]      difficulty,
  output logic [63:0]       start_nonce,
  output logic [CTRL_W-1:0] control,
  input  logic [63:0]       solution,
  input  logic [2:0]        status,
  input  logic              miner_irq,
  output logic              irq
);

  logic [63:0]       nonce_reg;
  logic [CTRL_W-1:0] control_reg;
  logic              irq_pending_reg;
  logic              irq_enable_reg;
  logic              irq_reg;
  logic              miner_irq_d_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       readdata_reg;
  logic [31:0]       readdata_next;

  logic        inputs_wr_ok;
  logic        ctrl_wr;
  logic        irq_ctrl_wr;
  logic        irq_rise;
  logic        run_start;
  logic [31:0] sol_lo, sol_hi_snap, cnt_lo, cnt_hi_snap;

  // Engine inputs are frozen while a run is in progress.
  assign inputs_wr_ok = avs.write & ~control_reg[0];
  assign ctrl_wr      = avs.write && (avs.address == ADDR_W'(CTRL));
  assign irq_ctrl_wr  = avs.write && (avs.address == ADDR_W'(IRQ_CTRL));
  assign irq_rise     = miner_irq & ~miner_irq_d_reg;
  assign run_start    = ctrl_wr & avs.writedata[0] & ~control_reg[0];

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      logic [31:0] hdr_word_reg;
      logic [31:0] diff_word_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hdr_word_reg  <= '0;
          diff_word_reg <= '0;
        end else begin
          if (inputs_wr_ok && avs.address == ADDR_W'(HDR_BASE + gi))
            hdr_word_reg <= avs.writedata;
          if (inputs_wr_ok && avs.address == ADDR_W'(DIFF_BASE + gi))
            diff_word_reg <= avs.writedata;
        end
      end

      assign header[32*gi +: 32]     = hdr_word_reg;
      assign difficulty[32*gi +: 32] = diff_word_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nonce_reg       <= '0;
      control_reg     <= '0;
      irq_pending_reg <= 1'b0;
      irq_enable_reg  <= 1'b0;
      irq_reg         <= 1'b0;
      miner_irq_d_reg <= 1'b0;
      cnt_reg         <= '0;
      readdata_reg    <= '0;
    end else begin
      if (inputs_wr_ok && avs.address == ADDR_W'(NONCE_LO)) nonce_reg[31:0]  <= avs.writedata;
      if (inputs_wr_ok && avs.address == ADDR_W'(NONCE_HI)) nonce_reg[63:32] <= avs.writedata;
      if (ctrl_wr)     control_reg    <= avs.writedata[CTRL_W-1:0];
      if (irq_ctrl_wr) irq_enable_reg <= avs.writedata[IRQ_EN_BIT];

      // A fresh engine edge beats a simultaneous software clear.
      miner_irq_d_reg <= miner_irq;
      if (irq_rise)
        irq_pending_reg <= 1'b1;
      else if (irq_ctrl_wr && avs.writedata[IRQ_CLR_BIT])
        irq_pending_reg <= 1'b0;
      irq_reg <= irq_pending_reg & irq_enable_reg;

      if (run_start)
        cnt_reg <= '0;
      else if (status[1] && !miner_irq && cnt_reg != '1)
        cnt_reg <= cnt_reg + CNT_W'(1);

      if (avs.read) readdata_reg <= readdata_next;
    end
  end

  snap64_reader u_sol_snap (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (solution),
    .lo_rd   (avs.read && avs.address == ADDR_W'(SOL_LO)),
    .lo      (sol_lo),
    .hi_snap (sol_hi_snap)
  );

  snap64_reader u_cnt_snap (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (64'(cnt_reg)),
    .lo_rd   (avs.read && avs.address == ADDR_W'(CNT_LO)),
    .lo      (cnt_lo),
    .hi_snap (cnt_hi_snap)
  );

  always_comb begin
    readdata_next = '0;
    if (avs.address < ADDR_W'(DIFF_BASE)) begin
      readdata_next = header[{avs.address[2:0], 5'd0} +: 32];
    end else if (avs.address < ADDR_W'(NONCE_LO)) begin
      readdata_next = difficulty[{avs.address[2:0], 5'd0} +: 32];
    end else begin
      case (avs.address)
        ADDR_W'(NONCE_LO): readdata_next = nonce_reg[31:0];
        ADDR_W'(NONCE_HI): readdata_next = nonce_reg[63:32];
        ADDR_W'(CTRL):     readdata_next = 32'(control_reg);
        ADDR_W'(SOL_LO):   readdata_next = sol_lo;
        ADDR_W'(SOL_HI):   readdata_next = sol_hi_snap;
        ADDR_W'(STATUS):   readdata_next = {27'b0, irq_pending_reg, irq_enable_reg, status};
        ADDR_W'(IRQ_CTRL): readdata_next = {31'b0, irq_enable_reg};
        ADDR_W'(CNT_LO):   readdata_next = cnt_lo;
        ADDR_W'(CNT_HI):   readdata_next = cnt_hi_snap;
        default:           readdata_next = '0;
      endcase
    end
  end

  assign avs.readdata = readdata_reg;
  assign start_nonce  = nonce_reg;
  assign control      = control_reg;
  assign irq          = irq_reg;

endmodule

// File: tb/tb_sha3_miner_csr.sv
// Self-checking bench for sha3_miner_csr: directed scenarios plus randomized
// register traffic checked against an array-based model of the register map.
module tb_sha3_miner_csr;
  import sha3_miner_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] header, difficulty;
  logic [63:0]  start_nonce;
  logic [17:0]  control;
  logic [63:0]  solution;
  logic [2:0]   status;
  logic         miner_irq;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Software-visible model of the writable part of the map.
  logic [31:0] m_words [0:17];
  logic [17:0] m_ctrl;

  sha3_miner_csr_if #(.ADDR_W(5)) avs_bus ();

  sha3_miner_csr #(.ADDR_W(5), .CTRL_W(18), .CNT_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .avs         (avs_bus),
    .header      (header),
    .difficulty  (difficulty),
    .start_nonce (start_nonce),
    .control     (control),
    .solution    (solution),
    .status      (status),
    .miner_irq   (miner_irq),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_bus.address   = a;
    avs_bus.writedata = d;
    avs_bus.write     = 1'b1;
    @(negedge clk);
    avs_bus.write     = 1'b0;
    $display("WR addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_bus.address = a;
    avs_bus.read    = 1'b1;
    @(negedge clk);
    avs_bus.read    = 1'b0;
    d = avs_bus.readdata;
    $display("RD addr=0x%02h data=0x%08h", a, d);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a <= 5'h11) return m_words[a];
    if (a == 5'h12) return 32'(m_ctrl);
    return 32'h0;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      bus_read(5'(a), d);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=0x%02h got=0x%08h exp=0x00000000", a, d);
      end
    end
    n_checks++;
    if (irq !== 1'b0 || header !== '0 || start_nonce !== '0 || control !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs irq=%0b ctrl=0x%05h exp all zero", irq, control);
    end
  endtask

  task automatic test_header();
    logic [31:0] d, held;
    bus_write(5'h00, 32'h11223344);
    bus_write(5'h07, 32'hAABBCCDD);
    n_checks++;
    if (header[31:0] !== 32'h11223344 || header[255:224] !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL header_out got=0x%08h/0x%08h exp=0x11223344/0xaabbccdd",
               header[31:0], header[255:224]);
    end
    bus_read(5'h07, d);
    n_checks++;
    if (d !== 32'hAABBCCDD) begin
      n_fail++;
      $display("FAIL header_rd7 got=0x%08h exp=0xaabbccdd", d);
    end
    bus_read(5'h00, held);
    n_checks++;
    if (held !== 32'h11223344) begin
      n_fail++;
      $display("FAIL header_rd0 got=0x%08h exp=0x11223344", held);
    end
    // readdata must hold while idle
    avs_bus.address = 5'h07;
    repeat (3) @(negedge clk);
    n_checks++;
    if (avs_bus.readdata !== 32'h11223344) begin
      n_fail++;
      $display("FAIL readdata_hold got=0x%08h exp=0x11223344", avs_bus.readdata);
    end
    // same-cycle read and write returns the old contents
    @(negedge clk);
    avs_bus.address   = 5'h00;
    avs_bus.writedata = 32'hDEADBEEF;
    avs_bus.write     = 1'b1;
    avs_bus.read      = 1'b1;
    @(negedge clk);
    avs_bus.write = 1'b0;
    avs_bus.read  = 1'b0;
    n_checks++;
    if (avs_bus.readdata !== 32'h11223344) begin
      n_fail++;
      $display("FAIL rd_wr_same got=0x%08h exp=0x11223344", avs_bus.readdata);
    end
    bus_read(5'h00, d);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_after_wr got=0x%08h exp=0xdeadbeef", d);
    end
  endtask

  task automatic test_write_lock();
    logic [255:0] hdr_before;
    bus_write(5'h12, 32'h1);
    hdr_before = header;
    bus_write(5'h10, 32'hFFFFFFFF);
    bus_write(5'h01, 32'h55555555);
    n_checks++;
    if (start_nonce !== 64'h0 || header !== hdr_before) begin
      n_fail++;
      $display("FAIL lock_ignored nonce=0x%016h exp=0x0000000000000000", start_nonce);
    end
    bus_write(5'h12, 32'h0);
    bus_write(5'h10, 32'hFFFFFFFF);
    n_checks++;
    if (start_nonce !== 64'h00000000_FFFFFFFF || control !== 18'h0) begin
      n_fail++;
      $display("FAIL unlock_write nonce=0x%016h exp=0x00000000ffffffff", start_nonce);
    end
  endtask

  task automatic test_random_rw();
    logic [31:0] d, e;
    logic [4:0]  a;
    int          r;
    bus_write(5'h12, 32'h0);
    m_ctrl = '0;
    for (int i = 0; i < 18; i++) begin
      m_words[i] = $urandom;
      bus_write(5'(i), m_words[i]);
    end
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 25));
      a = (r <= 18) ? 5'(r) : 5'(r + 6);
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        bus_write(a, d);
        if (a <= 5'h11 && !m_ctrl[0]) m_words[a] = d;
        else if (a == 5'h12) m_ctrl = d[17:0];
      end else begin
        bus_read(a, d);
        e = model_read(a);
        n_checks++;
        if (d !== e) begin
          n_fail++;
          $display("FAIL rand_read addr=0x%02h got=0x%08h exp=0x%08h", a, d, e);
        end
      end
    end
    n_checks++;
    if (start_nonce !== {m_words[17], m_words[16]} || control !== m_ctrl ||
        header[127:96] !== m_words[3] || difficulty[255:224] !== m_words[15]) begin
      n_fail++;
      $display("FAIL rand_outputs nonce=0x%016h exp=0x%016h ctrl=0x%05h exp=0x%05h",
               start_nonce, {m_words[17], m_words[16]}, control, m_ctrl);
    end
    bus_write(5'h12, 32'h0);
  endtask

  task automatic test_snap_solution();
    logic [31:0] d;
    solution = 64'h00000001_FFFFFFFF;
    bus_read(5'h13, d);
    n_checks++;
    if (d !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL sol_lo got=0x%08h exp=0xffffffff", d);
    end
    solution = 64'h00000002_00000000;
    bus_read(5'h14, d);
    n_checks++;
    if (d !== 32'h00000001) begin
      n_fail++;
      $display("FAIL sol_hi_snap got=0x%08h exp=0x00000001", d);
    end
    bus_read(5'h13, d);
    bus_read(5'h14, d);
    n_checks++;
    if (d !== 32'h00000002) begin
      n_fail++;
      $display("FAIL sol_hi_resnap got=0x%08h exp=0x00000002", d);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(5'h16, 32'h1);
    @(negedge clk);
    miner_irq = 1'b1;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_early got=%0b exp=0", irq);
    end
    @(negedge clk);
    miner_irq = 1'b0;
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_assert got=%0b exp=1", irq);
    end
    @(negedge clk);
    // clear collides with a new rising edge: pending must survive
    avs_bus.address   = 5'h16;
    avs_bus.writedata = 32'h3;
    avs_bus.write     = 1'b1;
    miner_irq         = 1'b1;
    @(negedge clk);
    avs_bus.write = 1'b0;
    miner_irq     = 1'b0;
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set_wins got=%0b exp=1", irq);
    end
    bus_read(5'h15, d);
    n_checks++;
    if (d !== 32'h18) begin
      n_fail++;
      $display("FAIL status_pending got=0x%08h exp=0x00000018", d);
    end
    bus_write(5'h16, 32'h3);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear got=%0b exp=0", irq);
    end
    bus_read(5'h15, d);
    n_checks++;
    if (d !== 32'h08) begin
      n_fail++;
      $display("FAIL status_cleared got=0x%08h exp=0x00000008", d);
    end
    // with enable off the edge is latched but irq stays low
    bus_write(5'h16, 32'h0);
    @(negedge clk) miner_irq = 1'b1;
    @(negedge clk) miner_irq = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked got=%0b exp=0", irq);
    end
    bus_write(5'h16, 32'h1);
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_unmask got=%0b exp=1", irq);
    end
    bus_write(5'h16, 32'h3);
  endtask

  task automatic test_counter();
    logic [31:0] lo, hi, lo2, hi2;
    int          run1, run2, exp_cnt;
    run1 = int'($urandom_range(40, 100));
    run2 = int'($urandom_range(5, 30));
    bus_write(5'h12, 32'h0);
    bus_write(5'h12, 32'h1);
    status = 3'b010;
    repeat (run1) @(negedge clk);
    // engine irq high pauses the count
    miner_irq = 1'b1;
    repeat (10) @(negedge clk);
    miner_irq = 1'b0;
    repeat (run2) @(negedge clk);
    status = 3'b000;
    exp_cnt = run1 + run2;
    bus_read(5'h17, lo);
    bus_read(5'h18, hi);
    n_checks++;
    if ({hi, lo} !== 64'(exp_cnt)) begin
      n_fail++;
      $display("FAIL cnt_value got=%0d exp=%0d", {hi, lo}, exp_cnt);
    end
    repeat (5) @(negedge clk);
    bus_write(5'h12, 32'h0);
    bus_read(5'h17, lo2);
    bus_read(5'h18, hi2);
    n_checks++;
    if ({hi2, lo2} !== 64'(exp_cnt)) begin
      n_fail++;
      $display("FAIL cnt_stable got=%0d exp=%0d", {hi2, lo2}, exp_cnt);
    end
    bus_write(5'h12, 32'h1);
    bus_read(5'h17, lo);
    bus_read(5'h18, hi);
    n_checks++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++;
      $display("FAIL cnt_restart got=%0d exp=0", {hi, lo});
    end
    bus_write(5'h12, 32'h0);
  endtask

  initial begin
    rst_n             = 1'b0;
    avs_bus.address   = '0;
    avs_bus.write     = 1'b0;
    avs_bus.writedata = '0;
    avs_bus.read      = 1'b0;
    solution          = '0;
    status            = '0;
    miner_irq         = 1'b0;

    test_reset();
    test_header();
    test_write_lock();
    test_random_rw();
    test_snap_solution();
    test_irq();
    test_counter();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_miner_csr.md
Name: sha3_miner_csr

Overview:
- Avalon-MM slave register bank that sits directly upstream and downstream of the SHA3-256 mining engine.
- Upstream: holds and drives the engine's header, difficulty, start_nonce and control inputs.
- Downstream: captures the engine's solution, status and irq outputs and presents them to the HPS.
- Adds a sticky interrupt with enable and clear, atomic 64-bit reads, and an elapsed-run cycle counter.

Parameters:
- ADDR_W, 5, word-address width.
- CTRL_W, 18, engine control width.
- CNT_W, 64, elapsed-cycle counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed latency 1.
- header  out  256  to engine.
- difficulty  out  256  to engine.
- start_nonce  out  64  to engine.
- control  out  CTRL_W  to engine.
- solution  in  64  from engine.
- status  in  3  from engine: {test, run, irq}.
- miner_irq  in  1  from engine.
- irq  out  1  to HPS interrupt controller.

Behaviour:
- Decision: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at posedge) clears header, difficulty, start_nonce, control, irq_pending, irq_enable, both snapshot registers, the counter and avs_readdata; irq=0.
- Address map (word offsets):
  - 0x00-0x07 header word i = bits [32i+31:32i], RW.
  - 0x08-0x0F difficulty, same packing, RW.
  - 0x10/0x11 start_nonce lo/hi, RW.
  - 0x12 control, bits [CTRL_W-1:0] RW, upper bits read 0.
  - 0x13 solution lo, RO.
  - 0x14 solution hi snapshot, RO.
  - 0x15 status = {27'b0, irq_pending, irq_enable, status[2:0]}, RO.
  - 0x16 irq_ctrl: bit0 irq_enable RW; bit1 write-1-clears irq_pending, reads 0.
  - 0x17 counter lo, RO.
  - 0x18 counter hi snapshot, RO.
  - All other addresses read 0; writes to them are ignored.
- Reads: avs_readdata is registered and valid the cycle after avs_read. No waitrequest. avs_readdata holds its value when avs_read=0.
- Atomic 64-bit read: reading 0x13 returns solution[31:0] and, in the same cycle, latches solution[63:32] into sol_hi_snap. Reading 0x14 returns sol_hi_snap. The counter at 0x17/0x18 uses the same scheme.
- Write lock: while control[0]=1, writes to 0x00-0x11 are ignored, so inputs never change mid-run. Control and irq_ctrl writes are always accepted.
- Interrupt:
  - irq_pending is set on a rising edge of miner_irq, detected against a 1-cycle delayed copy.
  - Writing bit1=1 at 0x16 clears irq_pending.
  - If set and clear occur in the same cycle, set wins.
  - irq = irq_pending & irq_enable, registered, with 1 cycle latency from pending.
- Elapsed counter:
  - Clears when a control write changes bit0 from 0 to 1.
  - Increments each cycle while status[1]=1 and miner_irq=0.
  - Saturates at all-ones and holds its value when stopped.
- Simultaneous read and write to the same address: the read returns the old value.

Decomposition:
- Package sha3_miner_pkg: address offset constants (HDR_BASE, DIFF_BASE, NONCE_LO/HI, CTRL, SOL_LO/HI, STATUS, IRQ_CTRL, CNT_LO/HI) and irq_ctrl bit positions.
- One natural sub-module, snap64_reader: a 64-bit source with lo-read strobe, producing the lo word and hi snapshot. It is instantiated twice, for solution and counter.

Test Plan:
- Reset then read all 25 addresses -> every read returns 0; irq=0.
- Write 0x11223344 to 0x00 and 0xAABBCCDD to 0x07 -> header[31:0]=0x11223344, header[255:224]=0xAABBCCDD; readback matches with 1-cycle latency.
- Write control=1, then write 0xFFFFFFFF to 0x10 -> start_nonce is unchanged. Write control=0, repeat the write -> start_nonce[31:0]=0xFFFFFFFF.
- Hold solution=0x00000001_FFFFFFFF, read 0x13, then change solution to 0x00000002_00000000 and read 0x14 -> reads return 0xFFFFFFFF then 0x00000001.
- Set irq_enable; pulse miner_irq high -> irq=1 two cycles after the edge. Write 0x3 to 0x16 on the same cycle as a new miner_irq rising edge -> pending stays 1. Write 0x3 alone -> irq=0 next cycle.
- Write control=1 and hold status[1]=1 for 100 cycles, then drop it -> counter reads 100 (±1 for the write/run latency, fixed by the bench) and is stable afterwards. A new 0->1 control write clears it to 0.
